// File: rtl/cipher_port_arbiter.sv
// rtl/cipher_port_arbiter.sv - two-requester round-robin arbiter for the RC4 cipher Avalon-MM slave port
// Optional hold-grant lock enabled by defining CIPHER_ARB_LOCK_EN.
module cipher_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic              A_Read,
  input  logic              A_Writ,
  input  logic [DATA_W-1:0] A_DataWr,
  input  logic              A_Lock,
  output logic              A_WaitReq,
  output logic [DATA_W-1:0] A_DataRd,
  output logic              A_RdValid,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic              B_Read,
  input  logic              B_Writ,
  input  logic [DATA_W-1:0] B_DataWr,
  input  logic              B_Lock,
  output logic              B_WaitReq,
  output logic [DATA_W-1:0] B_DataRd,
  output logic              B_RdValid,
  output logic [ADDR_W-1:0] Cpu_Addr,
  output logic              Cpu_Sel,
  output logic              Cpu_Read,
  output logic              Cpu_Writ,
  output logic [DATA_W-1:0] Cpu_DataWr,
  input  logic [DATA_W-1:0] Cpu_DataRd,
  output logic              Arb_Err
);

  logic req_a, req_b, contended;
  logic ptr_b, ptr_b_next;  // priority pointer: 0 = A holds it, 1 = B
  logic prio;               // effective priority used for this cycle's grant
  logic grant_a, grant_b, accept;
  logic win_read, win_writ;
  logic cpu_id;             // requester of the command currently on Cpu_*
  logic [READ_LAT-1:0] tag_v, tag_id;

  assign req_a     = A_Read | A_Writ;
  assign req_b     = B_Read | B_Writ;
  assign contended = req_a & req_b;

`ifdef CIPHER_ARB_LOCK_EN
  // A locked holder defers the pointer move it would have made; the deferred
  // move is paid back the cycle the holder drops Lock.
  logic owed, owed_next, holder_lock;

  assign holder_lock = ptr_b ? B_Lock : A_Lock;
  assign prio        = ptr_b ^ (owed & ~holder_lock);

  always_comb begin
    ptr_b_next = ptr_b;
    owed_next  = owed;
    if (!holder_lock) begin
      ptr_b_next = contended ? ~prio : prio;
      owed_next  = 1'b0;
    end else if (contended) begin
      owed_next  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) owed <= 1'b0;
    else          owed <= owed_next;
  end
`else
  logic unused_lock;
  assign unused_lock = A_Lock ^ B_Lock;
  assign prio        = ptr_b;
  assign ptr_b_next  = contended ? ~ptr_b : ptr_b;
`endif

  assign grant_a = Reset_n & req_a & (~req_b | ~prio);
  assign grant_b = Reset_n & req_b & (~req_a | prio);
  assign accept  = grant_a | grant_b;

  assign A_WaitReq = ~grant_a;
  assign B_WaitReq = ~grant_b;

  assign win_read = grant_b ? B_Read : A_Read;
  assign win_writ = grant_b ? B_Writ : A_Writ;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_b      <= 1'b0;
      Cpu_Sel    <= 1'b0;
      Cpu_Read   <= 1'b0;
      Cpu_Writ   <= 1'b0;
      Cpu_Addr   <= '0;
      Cpu_DataWr <= '0;
      cpu_id     <= 1'b0;
      Arb_Err    <= 1'b0;
    end else begin
      ptr_b    <= ptr_b_next;
      Cpu_Sel  <= accept;
      // Read+Writ together degrades to a plain write.
      Cpu_Read <= accept & win_read & ~win_writ;
      Cpu_Writ <= accept & win_writ;
      if (accept) begin
        Cpu_Addr   <= grant_b ? B_Addr : A_Addr;
        Cpu_DataWr <= grant_b ? B_DataWr : A_DataWr;
        cpu_id     <= grant_b;
      end
      if ((A_Read & A_Writ) | (B_Read & B_Writ)) Arb_Err <= 1'b1;
    end
  end

  // Tag pipeline: stage READ_LAT-1 lines up with Cpu_DataRd for that read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= Cpu_Read;
      tag_id[0] <= cpu_id;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign A_RdValid = tag_v[READ_LAT-1] & ~tag_id[READ_LAT-1];
  assign B_RdValid = tag_v[READ_LAT-1] &  tag_id[READ_LAT-1];
  assign A_DataRd  = Cpu_DataRd;
  assign B_DataRd  = Cpu_DataRd;

endmodule
